// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI burst engine.
// Build option: HPI_KEYCODE_SNOOP_EN enables keycode snooping in hpi_xfer_engine.
package hpi_pkg;

   typedef enum logic [3:0] {
      IDLE,
      A_SETUP,
      A_STROBE,
      A_HOLD,
      D_WAIT,
      D_SETUP,
      D_STROBE,
      D_HOLD,
      RD_STALL
   } hpi_state_e;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   // Phase lengths are limited to 2**PHASE_CNT_W cycles.
   localparam int PHASE_CNT_W = 8;

   function automatic logic is_addr_phase(input hpi_state_e s);
      return (s == A_SETUP) || (s == A_STROBE) || (s == A_HOLD);
   endfunction

   function automatic logic is_data_phase(input hpi_state_e s);
      return (s == D_SETUP) || (s == D_STROBE) || (s == D_HOLD);
   endfunction

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter that times the setup/strobe/hold phases of an HPI access.
// Loading N-1 on phase entry makes o_phase_done rise on the phase's last cycle.
module hpi_phase_timer
   import hpi_pkg::*;
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_load,
   input  logic [PHASE_CNT_W-1:0] i_load_val,
   output logic                   o_phase_done
);

   logic [PHASE_CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - PHASE_CNT_W'(1);
      end
   end

   assign o_phase_done = (r_count == '0);

endmodule

// File: rtl/hpi_xfer_engine.sv
// Autonomous CY7C67200 HPI burst sequencer: one ADDRESS write, then N DATA accesses.
// Build option: HPI_KEYCODE_SNOOP_EN captures the keycode byte from reads of KEYCODE_ADDR.
module hpi_xfer_engine
   import hpi_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 8,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2
`ifdef HPI_KEYCODE_SNOOP_EN
   ,
   parameter logic [15:0] KEYCODE_ADDR = 16'h051C
`endif
)(
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [15:0]       cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic [1:0]        hpi_addr,
   output logic              hpi_cs_n,
   output logic              hpi_r_n,
   output logic              hpi_w_n,
   output logic [DATA_W-1:0] hpi_data_out,
   output logic              hpi_data_oe,
   input  logic [DATA_W-1:0] hpi_data_in,
   output logic [7:0]        keycode
);

   hpi_state_e             r_state;
   hpi_state_e             w_next;
   logic                   r_write;
   logic [LEN_W-1:0]       r_remaining;
   logic                   r_rd_valid;
   logic [DATA_W-1:0]      r_rd_data;
   logic                   r_cs_n;
   logic                   r_r_n;
   logic                   r_w_n;
   logic [1:0]             r_addr_sel;
   logic                   r_oe;
   logic [DATA_W-1:0]      r_data_out;
   logic                   w_load;
   logic [PHASE_CNT_W-1:0] w_load_val;
   logic                   w_phase_done;
   logic                   w_accept;
   logic                   w_wr_take;
   logic                   w_capture;

   hpi_phase_timer u_timer (
      .i_clk        (clk_clk),
      .i_rst_n      (reset_reset_n),
      .i_load       (w_load),
      .i_load_val   (w_load_val),
      .o_phase_done (w_phase_done)
   );

   assign w_accept  = (r_state == IDLE) && cmd_valid;
   assign w_wr_take = (r_state == D_WAIT) && r_write && wr_valid;
   assign w_capture = (r_state == D_STROBE) && !r_write && w_phase_done;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (cmd_valid) w_next = A_SETUP;
         A_SETUP:  if (w_phase_done) w_next = A_STROBE;
         A_STROBE: if (w_phase_done) w_next = A_HOLD;
         A_HOLD:   if (w_phase_done) w_next = (r_remaining == '0) ? IDLE : D_WAIT;
         D_WAIT:   if (!r_write || wr_valid) w_next = D_SETUP;
         D_SETUP:  if (w_phase_done) w_next = D_STROBE;
         D_STROBE: if (w_phase_done) w_next = D_HOLD;
         D_HOLD: begin
            if (w_phase_done) begin
               if (!r_write) w_next = RD_STALL;
               else          w_next = (r_remaining == LEN_W'(1)) ? IDLE : D_WAIT;
            end
         end
         RD_STALL: if (rd_ready) w_next = (r_remaining == '0) ? IDLE : D_WAIT;
         default:  w_next = IDLE;
      endcase
   end

   // Reload the phase timer only when entering a timed phase.
   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (w_next)
         A_SETUP, D_SETUP: begin
            w_load     = (w_next != r_state);
            w_load_val = PHASE_CNT_W'(SETUP_CYC - 1);
         end
         A_STROBE, D_STROBE: begin
            w_load     = (w_next != r_state);
            w_load_val = PHASE_CNT_W'(STROBE_CYC - 1);
         end
         A_HOLD, D_HOLD: begin
            w_load     = (w_next != r_state);
            w_load_val = PHASE_CNT_W'(HOLD_CYC - 1);
         end
         default: begin
            w_load     = 1'b0;
            w_load_val = '0;
         end
      endcase
   end

   // Pin controls are registered from the next state so the HPI pins never glitch.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_remaining <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_cs_n      <= 1'b1;
         r_r_n       <= 1'b1;
         r_w_n       <= 1'b1;
         r_addr_sel  <= HPI_DATA;
         r_oe        <= 1'b0;
         r_data_out  <= '0;
      end else begin
         r_state    <= w_next;
         r_cs_n     <= !(is_addr_phase(w_next) || is_data_phase(w_next));
         r_w_n      <= !((w_next == A_STROBE) || ((w_next == D_STROBE) && r_write));
         r_r_n      <= !((w_next == D_STROBE) && !r_write);
         r_addr_sel <= is_addr_phase(w_next) ? HPI_ADDRESS : HPI_DATA;
         r_oe       <= is_addr_phase(w_next) || (is_data_phase(w_next) && r_write);
         if (w_accept) begin
            r_write     <= cmd_write;
            r_remaining <= cmd_len;
            r_data_out  <= DATA_W'(cmd_addr);
         end
         if (w_wr_take) begin
            r_data_out <= wr_data;
         end
         if (w_capture) begin
            r_rd_data <= hpi_data_in;
         end
         if ((r_state == D_HOLD) && w_phase_done) begin
            r_remaining <= r_remaining - LEN_W'(1);
            if (!r_write) r_rd_valid <= 1'b1;
         end
         if ((r_state == RD_STALL) && rd_ready) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

`ifdef HPI_KEYCODE_SNOOP_EN
   logic       r_snoop_pending;
   logic [7:0] r_keycode;

   // Only the first word of a read burst starting at KEYCODE_ADDR carries the keycode.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_snoop_pending <= 1'b0;
         r_keycode       <= 8'h00;
      end else begin
         if (w_accept) begin
            r_snoop_pending <= !cmd_write && (cmd_addr == KEYCODE_ADDR);
         end else if (w_capture) begin
            r_snoop_pending <= 1'b0;
         end
         if (w_capture && r_snoop_pending) begin
            r_keycode <= hpi_data_in[7:0];
         end
      end
   end

   assign keycode = r_keycode;
`else
   assign keycode = 8'h00;
`endif

   assign cmd_ready    = (r_state == IDLE);
   assign busy         = (r_state != IDLE);
   assign wr_ready     = w_wr_take;
   assign rd_valid     = r_rd_valid;
   assign rd_data      = r_rd_data;
   assign hpi_addr     = r_addr_sel;
   assign hpi_cs_n     = r_cs_n;
   assign hpi_r_n      = r_r_n;
   assign hpi_w_n      = r_w_n;
   assign hpi_data_out = r_data_out;
   assign hpi_data_oe  = r_oe;

endmodule
